// File: rtl/uart_tx_engine.sv
// UART transmit serializer: frames one word per request (start, 5-8 data LSB-first,
// optional parity, 1-2 stop) on bit ticks from tx_clk. Parity support built only with UART_TX_PARITY_EN.
module uart_tx_engine #(
    parameter int   DW       = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_clk,
    input  logic          newd,
    input  logic [DW-1:0] tx_data,
    input  logic [3:0]    length,
    input  logic          parity_en,
    input  logic          parity_type,
    input  logic          stop2,
    output logic          tx,
    output logic          busy,
    output logic          donetx
);

    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_STOP1,
        S_STOP2,
        S_DONE
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t        state, state_n;
    logic          tx_q, tx_n;
    logic [3:0]    count_q, count_n;
    logic [DW-1:0] data_q;
    logic [3:0]    len_q;
    logic [3:0]    len_eff;
    logic          stop2_q;
    logic          tx_clk_q;
    logic          tick;
    logic          accept;

    assign tick    = tx_clk & ~tx_clk_q;
    assign len_eff = (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;

`ifdef UART_TX_PARITY_EN
    logic parity_en_q;
    logic parity_type_q;
    logic par_bit;

    // Parity covers only the bits actually sent; bits above the frame length are masked out.
    always_comb begin
        par_bit = parity_type_q;
        for (int i = 0; i < DW; i++) begin
            if (i < int'(len_q)) begin
                par_bit = par_bit ^ data_q[i];
            end
        end
    end
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_type;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_q     <= IDLE_LVL;
            count_q  <= 4'd0;
            tx_clk_q <= 1'b0;
            data_q   <= '0;
            len_q    <= 4'd8;
            stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_q   <= 1'b0;
            parity_type_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tx_q     <= tx_n;
            count_q  <= count_n;
            tx_clk_q <= tx_clk;
            if (accept) begin
                data_q  <= tx_data;
                len_q   <= len_eff;
                stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
                parity_en_q   <= parity_en;
                parity_type_q <= parity_type;
`endif
            end
        end
    end

    // Each transition on a tick drives the line value for the bit period that tick begins.
    always_comb begin
        state_n = state;
        tx_n    = tx_q;
        count_n = count_q;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = IDLE_LVL;
                if (newd) begin
                    accept  = 1'b1;
                    state_n = S_ARM;
                end
            end
            S_ARM: begin
                if (tick) begin
                    tx_n    = ~IDLE_LVL;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_n    = data_q[0];
                    count_n = 4'd1;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (count_q < len_q) begin
                        tx_n    = data_q[count_q[IW-1:0]];
                        count_n = count_q + 4'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        if (parity_en_q) begin
                            tx_n    = par_bit;
                            state_n = S_PARITY;
                        end else begin
                            tx_n    = IDLE_LVL;
                            state_n = S_STOP1;
                        end
`else
                        tx_n    = IDLE_LVL;
                        state_n = S_STOP1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tx_n    = IDLE_LVL;
                    state_n = S_STOP1;
                end
            end
`endif
            S_STOP1: begin
                if (tick) begin
                    state_n = stop2_q ? S_STOP2 : S_DONE;
                end
            end
            S_STOP2: begin
                if (tick) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                tx_n    = IDLE_LVL;
                count_n = 4'd0;
                state_n = S_IDLE;
            end
            default: begin
                tx_n    = IDLE_LVL;
                state_n = S_IDLE;
            end
        endcase
    end

    assign tx     = tx_q;
    assign busy   = (state != S_IDLE);
    assign donetx = (state == S_DONE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed and random frames compared cycle by cycle
// against a frame model built from the line protocol (bit list indexed by ticks since acceptance).
module tb_uart_tx_engine;

    logic       clk;
    logic       rst;
    logic       tx_clk;
    logic       newd;
    logic [7:0] tx_data;
    logic [3:0] length;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic       tx;
    logic       busy;
    logic       donetx;

    int vectors     = 0;
    int miscompares = 0;

    int   tick_cnt    = 0;
    logic tx_clk_prev = 1'b0;

    uart_tx_engine #(.DW(8), .IDLE_LVL(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_clk      (tx_clk),
        .newd        (newd),
        .tx_data     (tx_data),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .tx          (tx),
        .busy        (busy),
        .donetx      (donetx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud clock edges land 3 ns before clk posedges, with a varying half-period of 3-6 clks.
    initial begin
        tx_clk = 1'b0;
        #2;
        forever begin
            #($urandom_range(3, 6) * 10);
            tx_clk = ~tx_clk;
        end
    end

    // Count bit ticks the way the line protocol defines them: rising tx_clk seen at a clk edge.
    always @(posedge clk) begin
        if (rst) begin
            tx_clk_prev = 1'b0;
        end else begin
            if (tx_clk && !tx_clk_prev) begin
                tick_cnt++;
            end
            tx_clk_prev = tx_clk;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("reset_tx", tx, 1'b1);
            checkOutput("reset_busy", busy, 1'b0);
            checkOutput("reset_donetx", donetx, 1'b0);
        end
        rst = 1'b0;
    endtask

    // Sends one frame and checks tx/busy/donetx every cycle; junk=1 scribbles on all inputs
    // while busy, abort_d>=0 asserts reset once the given bit period is reached.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] len, input logic pen,
                                 input logic ptype, input logic s2, input bit junk, input int abort_d);
        logic       exp_bits[$];
        logic [7:0] kept;
        int         eff;
        int         nbits;
        int         t0;
        int         d;
        int         guard;
        bit         finished;

        eff  = (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
        kept = data;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < eff) exp_bits.push_back(data[i]);
            else         kept[i] = 1'b0;
        end
`ifdef UART_TX_PARITY_EN
        if (pen) exp_bits.push_back(logic'($countones(kept) % 2) ^ ptype);
`endif
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
        nbits = exp_bits.size();

        @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_tx", tx, 1'b1);
        tx_data     = data;
        length      = len;
        parity_en   = pen;
        parity_type = ptype;
        stop2       = s2;
        newd        = 1'b1;
        @(posedge clk);
        #1;
        t0   = tick_cnt;
        newd = 1'b0;

        guard    = 0;
        finished = 1'b0;
        while (!finished && guard <= 400) begin
            @(negedge clk);
            guard++;
            d = tick_cnt - t0;
            if (abort_d >= 0 && d == abort_d) begin
                checkOutput("pre_abort_tx", tx, exp_bits[d-1]);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("abort_tx", tx, 1'b1);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_donetx", donetx, 1'b0);
                repeat (20) begin
                    @(negedge clk);
                    checkOutput("post_abort_donetx", donetx, 1'b0);
                    checkOutput("post_abort_busy", busy, 1'b0);
                end
                finished = 1'b1;
            end else if (d == 0) begin
                checkOutput("arm_tx", tx, 1'b1);
                checkOutput("arm_busy", busy, 1'b1);
                checkOutput("arm_donetx", donetx, 1'b0);
            end else if (d <= nbits) begin
                checkOutput($sformatf("bit%0d_tx", d - 1), tx, exp_bits[d-1]);
                checkOutput("frame_busy", busy, 1'b1);
                checkOutput("frame_donetx", donetx, 1'b0);
            end else begin
                checkOutput("done_donetx", donetx, 1'b1);
                checkOutput("done_busy", busy, 1'b1);
                checkOutput("done_tx", tx, 1'b1);
                finished = 1'b1;
            end
            if (junk) begin
                newd        = finished ? 1'b0 : 1'($urandom);
                tx_data     = 1'($urandom) ? 8'h00 : 8'($urandom);
                length      = 4'($urandom);
                parity_en   = 1'($urandom);
                parity_type = 1'($urandom);
                stop2       = 1'($urandom);
            end
        end
        newd = 1'b0;
        checkOutput("frame_timeout", guard > 400, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        newd        = 1'b0;
        tx_data     = 8'h00;
        length      = 4'd8;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop2       = 1'b0;

        doReset(12);
        $display("[TB] reset checks done");

        applyStimulus(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(8'hA3, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(8'hA3, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        applyStimulus(8'hFF, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        applyStimulus(8'h3C, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(8'h96, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        applyStimulus(8'hC5, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'h5A, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        $display("[TB] directed frames done");

        applyStimulus(8'hB7, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        applyStimulus(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        $display("[TB] mid-frame reset done");

        for (int n = 0; n < 25; n++) begin
            applyStimulus(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), -1);
        end
        $display("[TB] random frames done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
